// File: rtl/rv32_pkg.sv
// rv32_pkg: shared fetch types (hart id, buffered fetch entry) and instruction size
package rv32_pkg;
  localparam int RV32_INSTR_BYTES = 4;
  typedef logic [3:0] rv_hart_id_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    rv_hart_id_t hart;
  } fetch_entry_t;
endpackage

// File: rtl/rv32_fetch_fifo.sv
// rv32_fetch_fifo: ordered fetch buffer; ports clk/rst, push/push_entry, pop, sq_valid/sq_hart squash-with-compaction, head/count
module rv32_fetch_fifo import rv32_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         sq_valid,
  input  rv_hart_id_t  sq_hart,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    int n;
    mem_d = '{default: '0};
    n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count_q) && !(pop && i == 0) && !(sq_valid && mem_q[i].hart == sq_hart)) begin
        mem_d[n] = mem_q[i];
        n++;
      end
    end
    if (push && n < DEPTH) begin
      mem_d[n] = push_entry;
      n++;
    end
    count_d = CW'(n);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end
  assign head  = mem_q[0];
  assign count = count_q;
endmodule

// File: rtl/rv32_barrel_fetch.sv
// rv32_barrel_fetch: round-robin multi-hart fetch; ports rv32_clk/rv32_rst, hart_enable, i_req/i_addr/i_data imem, redirect_*, instr_* decode handshake
module rv32_barrel_fetch import rv32_pkg::*; #(
  parameter int NUM_HARTS = 4,
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0080,
  parameter int FIFO_DEPTH = 2,
  localparam int HART_W = NUM_HARTS > 1 ? $clog2(NUM_HARTS) : 1
) (
  input  logic                 rv32_clk,
  input  logic                 rv32_rst,
  input  logic [NUM_HARTS-1:0] hart_enable,
  output logic                 i_req,
  output logic [XLEN-1:0]      i_addr,
  input  logic [31:0]          i_data,
  input  logic                 redirect_valid,
  input  logic [HART_W-1:0]    redirect_hart,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [31:0]          instr,
  output logic [XLEN-1:0]      instr_pc,
  output logic [HART_W-1:0]    instr_hart
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [XLEN-1:0] pc_q [NUM_HARTS];
  logic [XLEN-1:0] pc_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] out_q, out_d, redir, elig;
  logic [HART_W-1:0] rr_q, rr_d, if_hart_q, sel;
  logic [XLEN-1:0] if_pc_q;
  logic if_q, found, pop, push, room;
  logic [CW-1:0] count;
  fetch_entry_t head, push_entry;
  function automatic logic [HART_W:0] rr_pick(input logic [NUM_HARTS-1:0] el, input logic [HART_W-1:0] ptr);
    logic [HART_W:0] r;
    r = '0;
    for (int k = NUM_HARTS; k >= 1; k--)
      if (el[(int'(ptr) + k) % NUM_HARTS]) r = {1'b1, HART_W'((int'(ptr) + k) % NUM_HARTS)};
    return r;
  endfunction
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) redir[h] = redirect_valid && int'(redirect_hart) == h;
    elig = hart_enable & ~out_q & ~redir;
  end
  assign {found, sel} = rr_pick(elig, rr_q);
  assign pop   = instr_valid & instr_ready;
  assign room  = int'(count) + int'(if_q) - int'(pop) < FIFO_DEPTH;
  assign i_req = !rv32_rst && found && room;
  assign i_addr = i_req ? pc_q[sel] : '0;
  // A word returning for a hart redirected this cycle is stale and never enters the buffer.
  assign push = if_q && !(redirect_valid && redirect_hart == if_hart_q);
  assign push_entry = fetch_entry_t'{instr: i_data, pc: 32'(if_pc_q), hart: rv_hart_id_t'(if_hart_q)};
  always_comb begin
    pc_d  = pc_q;
    out_d = out_q;
    rr_d  = rr_q;
    if (i_req) begin
      pc_d[sel]  = pc_q[sel] + XLEN'(RV32_INSTR_BYTES);
      out_d[sel] = 1'b1;
      rr_d       = sel;
    end
    for (int h = 0; h < NUM_HARTS; h++) begin
      if ((pop && int'(head.hart) == h) || redir[h]) out_d[h] = 1'b0;
      if (redir[h]) pc_d[h] = redirect_pc & ~XLEN'(3);
    end
  end
  always_ff @(posedge rv32_clk or posedge rv32_rst) begin
    if (rv32_rst) begin
      pc_q      <= '{default: RESET_PC};
      out_q     <= '0;
      rr_q      <= HART_W'(NUM_HARTS - 1);
      if_q      <= 1'b0;
      if_hart_q <= '0;
      if_pc_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      out_q     <= out_d;
      rr_q      <= rr_d;
      if_q      <= i_req;
      if_hart_q <= sel;
      if_pc_q   <= i_addr;
    end
  end
  rv32_fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk(rv32_clk),
    .rst(rv32_rst),
    .push(push),
    .push_entry(push_entry),
    .pop(pop),
    .sq_valid(redirect_valid),
    .sq_hart(rv_hart_id_t'(redirect_hart)),
    .head(head),
    .count(count)
  );
  assign instr_valid = count != '0;
  assign instr       = head.instr;
  assign instr_pc    = XLEN'(head.pc);
  assign instr_hart  = head.hart[HART_W-1:0];
endmodule

// File: tb/tb_rv32_barrel_fetch.sv
// tb_rv32_barrel_fetch: directed plus random checks of the barrel fetch against a queue-based reference model
module tb_rv32_barrel_fetch;
  localparam int NH = 4;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst, ready, rv, i_req, instr_valid;
  logic [3:0] en;
  logic [1:0] rh, instr_hart;
  logic [31:0] rpc, idata, i_addr, instr, instr_pc;
  typedef struct {
    logic [31:0] d;
    logic [31:0] pc;
    int h;
  } ent_t;
  ent_t m_q[$];
  logic [31:0] m_pc [NH];
  bit m_out [NH];
  int m_rr, m_ih;
  bit m_infl;
  logic [31:0] m_ipc;
  int checks = 0;
  int errors = 0;
  logic l_req, l_val;
  logic [31:0] l_addr;
  int l_hart, l_sel;
  rv32_barrel_fetch dut (
    .rv32_clk(clk),
    .rv32_rst(rst),
    .hart_enable(en),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_data(idata),
    .redirect_valid(rv),
    .redirect_hart(rh),
    .redirect_pc(rpc),
    .instr_valid(instr_valid),
    .instr_ready(ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_hart(instr_hart)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic bit has_h(input int h);
    foreach (m_q[i]) if (m_q[i].h == h) return 1'b1;
    return 1'b0;
  endfunction
  task automatic m_reset();
    m_q.delete();
    for (int i = 0; i < NH; i++) begin
      m_pc[i] = 32'h80;
      m_out[i] = 1'b0;
    end
    m_rr = NH - 1;
    m_infl = 1'b0;
    m_ih = 0;
    m_ipc = '0;
  endtask
  task automatic cyc();
    bit found, pop, room, ereq;
    int sel;
    idata = $urandom();
    #1;
    found = 1'b0;
    sel = 0;
    for (int k = 1; k <= NH; k++) begin
      int h;
      h = (m_rr + k) % NH;
      if (!found && en[h] && !m_out[h] && !(rv && int'(rh) == h)) begin
        found = 1'b1;
        sel = h;
      end
    end
    pop = m_q.size() > 0 && ready;
    room = m_q.size() + int'(m_infl) - int'(pop) < DEPTH;
    ereq = !rst && found && room;
    chk("i_req", 32'(i_req), 32'(ereq));
    if (ereq) chk("i_addr", i_addr, m_pc[sel]);
    chk("instr_valid", 32'(instr_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("instr", instr, m_q[0].d);
      chk("instr_pc", instr_pc, m_q[0].pc);
      chk("instr_hart", 32'(instr_hart), 32'(m_q[0].h));
    end
    l_req = i_req;
    l_addr = i_addr;
    l_val = instr_valid;
    l_hart = int'(instr_hart);
    l_sel = sel;
    if (rst) m_reset();
    else begin
      if (pop) begin
        m_out[m_q[0].h] = 1'b0;
        void'(m_q.pop_front());
      end
      if (rv) begin
        m_pc[rh] = rpc & ~32'h3;
        m_out[rh] = 1'b0;
        for (int i = m_q.size() - 1; i >= 0; i--) if (m_q[i].h == int'(rh)) m_q.delete(i);
      end
      if (m_infl && !(rv && int'(rh) == m_ih)) m_q.push_back('{idata, m_ipc, m_ih});
      m_infl = ereq;
      if (ereq) begin
        m_ipc = m_pc[sel];
        m_ih = sel;
        m_pc[sel] = m_pc[sel] + 32'd4;
        m_out[sel] = 1'b1;
        m_rr = sel;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    int exp_a[5] = '{'h80, 'h80, 'h80, 'h80, 'h84};
    int exp_h[5] = '{0, 1, 2, 3, 0};
    logic [31:0] a[7];
    int hv[7];
    logic vv[7], rq[7];
    bit got;
    int n;
    rst = 1'b1; en = '0; ready = 1'b0; rv = 1'b0; rh = '0; rpc = '0; idata = '0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_i_req", 32'(i_req), 32'd0);
    chk("rst_i_addr", i_addr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_instr_hart", 32'(instr_hart), 32'd0);
    rst = 1'b0; en = 4'hF; ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      a[i] = l_addr; hv[i] = l_hart; vv[i] = l_val; rq[i] = l_req;
    end
    for (int i = 0; i < 5; i++) begin
      chk("start_req", 32'(rq[i]), 32'd1);
      chk("start_addr", a[i], 32'(exp_a[i]));
      chk("start_valid", 32'(vv[i + 2]), 32'd1);
      chk("start_hart", 32'(hv[i + 2]), 32'(exp_h[i]));
    end
    chk("latency_v0", 32'(vv[0]), 32'd0);
    chk("latency_v1", 32'(vv[1]), 32'd0);
    ready = 1'b0;
    repeat (6) cyc();
    chk("stall_req", 32'(l_req), 32'd0);
    chk("stall_valid", 32'(l_val), 32'd1);
    ready = 1'b1;
    repeat (4) cyc();
    for (int i = 0; i < 60 && !has_h(1); i++) begin
      ready = 1'($urandom_range(0, 1));
      cyc();
    end
    chk("h1_buffered", 32'(has_h(1)), 32'd1);
    rv = 1'b1; rh = 2'd1; rpc = 32'h203; ready = 1'b0;
    cyc();
    rv = 1'b0; ready = 1'b1; got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      cyc();
      if (l_req && l_sel == 1) begin
        got = 1'b1;
        chk("h1_redir_addr", l_addr, 32'h200);
      end
    end
    chk("h1_reissue", 32'(got), 32'd1);
    for (int i = 0; i < 20 && !(m_infl && m_ih == 2); i++) cyc();
    chk("h2_inflight", 32'(m_infl && m_ih == 2), 32'd1);
    rv = 1'b1; rh = 2'd2; rpc = 32'h300;
    cyc();
    rv = 1'b0; got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      cyc();
      if (l_req && l_sel == 2) begin
        got = 1'b1;
        chk("h2_redir_addr", l_addr, 32'h300);
      end
    end
    chk("h2_reissue", 32'(got), 32'd1);
    en = 4'b0101;
    repeat (4) cyc();
    repeat (8) begin
      cyc();
      if (l_val) chk("en_even_hart", 32'(l_hart % 2), 32'd0);
    end
    for (int i = 0; i < 10 && !(m_infl && m_ih == 2); i++) cyc();
    chk("h2_inflight_dis", 32'(m_infl && m_ih == 2), 32'd1);
    en = 4'b0001;
    n = 0;
    repeat (6) begin
      cyc();
      if (l_val && l_hart == 2) n++;
    end
    chk("h2_after_disable", 32'(n > 0), 32'd1);
    en = 4'hF; ready = 1'b0;
    for (int i = 0; i < 10 && m_q.size() < 2; i++) cyc();
    chk("two_buffered", 32'(m_q.size() == 2), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_req", 32'(i_req), 32'd0);
    m_reset();
    @(negedge clk);
    cyc();
    rst = 1'b0; ready = 1'b1;
    cyc();
    chk("restart_req", 32'(l_req), 32'd1);
    chk("restart_addr", l_addr, 32'h80);
    cyc();
    cyc();
    chk("restart_valid", 32'(l_val), 32'd1);
    chk("restart_hart", 32'(l_hart), 32'd0);
    repeat (400) begin
      en = 4'($urandom());
      ready = $urandom_range(0, 3) != 0;
      rv = $urandom_range(0, 7) == 0;
      rh = 2'($urandom());
      rpc = $urandom();
      cyc();
    end
    rv = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
